pts_wrapper: RTL and testbench
==============================

# pts_wrapper

Parallel-to-serial converter: the transmit-side counterpart of the FFT block's serial-to-parallel input wrapper. It captures a full frame of NUM_WORDS 16-bit samples in one cycle, then emits them one word per accepted transfer on a valid/ready serial port. The frame is emitted in index order, word 0 first, so a serial-to-parallel stage on the far end rebuilds the identical array. It sits on the FFT output path, between the result array and the downstream sample stream.

## Interface
- NUM_WORDS, 48, words per frame (≥2)
- WORD_W, 16, bits per word
- clk  in  1  system clock (400 MHz target), all logic on rising edge
- n_rst  in  1  asynchronous, active-low reset
- load_strobe  in  1  active-high; captures data_par when idle
- data_par  in  [NUM_WORDS-1:0][WORD_W-1:0]  frame to transmit, word i = data_par[i]
- out_ready  in  1  downstream accepts current word
- serial_out  out  WORD_W  current word
- out_valid  out  1  serial_out holds a valid word
- out_last  out  1  current word is index NUM_WORDS-1
- busy  out  1  frame capture/transmit in progress
- done  out  1  one-cycle pulse after the final word is accepted

## Operation
- States: IDLE, SEND.
- IDLE: busy=0, out_valid=0, serial_out=0. When load_strobe=1, register all of data_par into the frame buffer, clear idx to 0, and go to SEND.
- SEND: busy=1, out_valid=1, serial_out=buf[idx], out_last=(idx==NUM_WORDS-1).
- Handshake: a transfer occurs on a rising edge with out_valid&&out_ready. On a transfer, idx increments.
- Without a transfer, serial_out, out_last and idx hold. The word is never dropped or changed while stalled.
- Final transfer (idx==NUM_WORDS-1 accepted): go to IDLE, pulse done for the next cycle, reset idx to 0.
- load_strobe is ignored in SEND, including in the cycle of the final transfer. The buffer is never overwritten mid-frame.
- data_par changes after capture have no effect on the frame in flight.
- idx width = $clog2(NUM_WORDS). Comparison is against NUM_WORDS-1, so idx never wraps past NUM_WORDS-1.
- Reset (any time, including mid-frame): state=IDLE, idx=0, buffer=0, all outputs 0. The frame is abandoned and done does not pulse.

## Timing
- Load latency: load_strobe sampled high at edge k gives out_valid=1 with word 0 from edge k.
- With out_ready held high, word i is presented during cycle k+i. The frame takes exactly NUM_WORDS cycles.
- done=1 in the single cycle after the edge that accepted the last word, coincident with busy=0.
- Minimum frame-to-frame gap: a new load_strobe is accepted at the edge ending the done cycle. There is one idle cycle between frames.
- out_ready low for n cycles stretches the frame by n cycles.

## Configuration
- Macro: PTS_LOAD_ERR_EN.
- Defined: adds output load_err (1 bit, reset 0). load_err is sticky; it sets on any edge where load_strobe=1 while busy=1, and clears only on reset.
- Not defined: no port, no logic. An ignored load_strobe is silent.

## Structure
- Shared package pts_pkg holds:
  - NUM_WORDS_DEF=48 and WORD_W_DEF=16
  - state enum pts_state_t {IDLE, SEND}
  - frame type pts_frame_t = logic [NUM_WORDS_DEF-1:0][WORD_W_DEF-1:0]
- One sub-module, pts_index_counter: the idx register with clear, enable (transfer) and terminal-count (out_last) outputs. The top level holds the FSM, frame buffer and output mux.

## Test plan
- Frame with data_par[i]=i (i=0..47), load_strobe for 1 cycle, out_ready=1 -> serial_out 0x0000..0x002F on 48 consecutive cycles. out_last high only on 0x002F. done pulses once, one cycle later.
- Same frame, out_ready low for 3 cycles while word 5 is presented -> serial_out holds 0x0005 for 4 cycles, then 6..47 follow. Total 51 cycles.
- load_strobe during word 10 with data_par all 0xFFFF -> the frame continues with 11..47 and no 0xFFFF appears. With PTS_LOAD_ERR_EN, load_err=1 and stays high.
- n_rst asserted while word 20 is presented -> out_valid, busy, serial_out and out_last go 0 immediately; no done pulse. After release, a new load emits word 0 first.
- Back-to-back: a second load_strobe (data_par[i]=0x100+i) asserted in the done cycle -> frame 2 starts at 0x0100 right after. A load_strobe in the final-transfer cycle is ignored.
- No load_strobe for 100 cycles after reset -> out_valid, busy and done remain 0 throughout.

Source files
------------

// File: rtl/pts_pkg.sv
// Shared types and defaults for the pts_wrapper parallel-to-serial converter.
// The optional load-collision flag is controlled by the PTS_LOAD_ERR_EN macro.
package pts_pkg;

    localparam int NUM_WORDS_DEF = 48;
    localparam int WORD_W_DEF    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } pts_state_t;

    typedef logic [NUM_WORDS_DEF-1:0][WORD_W_DEF-1:0] pts_frame_t;

endpackage : pts_pkg

// File: rtl/pts_index_counter.sv
// Word index register for the serializer: synchronous clear, advance on an accepted
// transfer, and a terminal-count flag for the final word of the frame.
module pts_index_counter #(
    parameter  int NUM_WORDS = 48,
    localparam int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             tc
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    assign tc  = (idx_q == LAST_IDX);
    assign idx = idx_q;

    // The last word returns the index to 0, so it never runs past NUM_WORDS-1.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (en) begin
            idx_d = tc ? '0 : idx_q + IDX_W'(1);
        end
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule : pts_index_counter

// File: rtl/pts_wrapper.sv
// Captures a NUM_WORDS frame in one cycle and streams it word 0 first on a valid/ready port.
// Define PTS_LOAD_ERR_EN to add a sticky load_err flag for strobes that arrive while busy.
module pts_wrapper
    import pts_pkg::*;
#(
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int WORD_W    = WORD_W_DEF
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             load_strobe,
    input  logic [NUM_WORDS-1:0][WORD_W-1:0] data_par,
    input  logic                             out_ready,
    output logic [WORD_W-1:0]                serial_out,
    output logic                             out_valid,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
`ifdef PTS_LOAD_ERR_EN
    ,
    output logic                             load_err
`endif
);

    localparam int IDX_W = $clog2(NUM_WORDS);

    pts_state_t                       state_q, state_d;
    logic [NUM_WORDS-1:0][WORD_W-1:0] frame_q, frame_d;
    logic                             done_q, done_d;
    logic [IDX_W-1:0]                 idx;
    logic                             idx_tc;
    logic                             idx_clr;
    logic                             xfer;
    logic                             sending;

    assign sending = (state_q == SEND);
    assign xfer    = sending && out_ready;

    pts_index_counter #(
        .NUM_WORDS (NUM_WORDS)
    ) u_idx (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (idx_clr),
        .en    (xfer),
        .idx   (idx),
        .tc    (idx_tc)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        idx_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_strobe) begin
                    frame_d = data_par;
                    idx_clr = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Strobes are ignored here; the buffer only changes from IDLE.
                if (xfer && idx_tc) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the frame buffer is reset along with the control state so that no
    // stale frame contents survive a reset; it is small enough to live in flops.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    assign busy       = sending;
    assign out_valid  = sending;
    assign out_last   = sending && idx_tc;
    assign serial_out = sending ? frame_q[idx] : '0;
    assign done       = done_q;

`ifdef PTS_LOAD_ERR_EN
    logic load_err_q, load_err_d;

    always_comb begin
        load_err_d = load_err_q | (load_strobe & sending);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;
`endif

endmodule : pts_wrapper

// File: tb/tb_pts_wrapper.sv
// Scoreboard bench for pts_wrapper: expected words are queued at load time and
// compared against serial_out as each transfer is accepted.
module tb_pts_wrapper;
    import pts_pkg::*;

    localparam int NW = NUM_WORDS_DEF;

    logic        clk;
    logic        n_rst;
    logic        load_strobe;
    pts_frame_t  data_par;
    logic        out_ready;
    logic [15:0] serial_out;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef PTS_LOAD_ERR_EN
    logic        load_err;
`endif

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_q[$];

    pts_wrapper dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .load_strobe (load_strobe),
        .data_par    (data_par),
        .out_ready   (out_ready),
        .serial_out  (serial_out),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
`ifdef PTS_LOAD_ERR_EN
        ,
        .load_err    (load_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fill_data(input int base);
        for (int i = 0; i < NW; i++) data_par[i] = 16'(base + i);
    endtask

    task automatic fill_const(input logic [15:0] v);
        for (int i = 0; i < NW; i++) data_par[i] = v;
    endtask

    // Drive a load at the next falling edge; the DUT captures it at the following rising edge.
    task automatic load_frame(input int base);
        @(negedge clk);
        fill_data(base);
        load_strobe = 1'b1;
        for (int i = 0; i < NW; i++) exp_q.push_back(16'(base + i));
    endtask

    // Runs one frame from its first word through the done cycle. stall_word/stall_len
    // hold out_ready low, inj_word raises a junk load_strobe, abort_word returns early,
    // next_base >= 0 loads another frame in the done cycle.
    task automatic drain(input int stall_word, input int stall_len, input int inj_word,
                         input int abort_word, input int next_base, input int exp_cycles);
        int cyc;
        int wi;
        int stall_left;
        bit finished;
        cyc        = 0;
        wi         = 0;
        stall_left = stall_len;
        finished   = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            load_strobe = 1'b0;
            fill_const(16'h5A5A);
            if (!out_valid) begin
                finished = 1'b1;
                break;
            end
            cyc++;
            if (wi == abort_word) return;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL word_%0d: serial_out=%h but no word expected", wi, serial_out);
            end else if (serial_out !== exp_q[0]) begin
                n_fail++;
                $display("FAIL word_%0d: serial_out=%h expected %h", wi, serial_out, exp_q[0]);
            end
            n_checks++;
            if (out_last !== (wi == NW - 1)) begin
                n_fail++;
                $display("FAIL last_%0d: out_last=%b expected %b", wi, out_last, (wi == NW - 1));
            end
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL inframe_%0d: busy=%b done=%b expected busy=1 done=0", wi, busy, done);
            end
            if (wi == stall_word && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (wi == inj_word) begin
                load_strobe = 1'b1;
                fill_const(16'hFFFF);
            end
            if (out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                wi++;
            end
        end
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL frame_timeout: out_valid still %b after 300 cycles", out_valid);
        end
        n_checks++;
        if (cyc != exp_cycles) begin
            n_fail++;
            $display("FAIL frame_len: %0d cycles expected %0d", cyc, exp_cycles);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d words never emitted", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || serial_out !== 16'h0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cycle: done=%b busy=%b serial_out=%h out_last=%b expected 1 0 0000 0",
                     done, busy, serial_out, out_last);
        end
        if (next_base >= 0) begin
            fill_data(next_base);
            load_strobe = 1'b1;
            for (int i = 0; i < NW; i++) exp_q.push_back(16'(next_base + i));
        end else begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL after_done: done=%b out_valid=%b expected 0 0", done, out_valid);
            end
        end
    endtask

    task automatic test_reset;
        n_rst       = 1'b0;
        load_strobe = 1'b0;
        out_ready   = 1'b1;
        fill_const(16'h0);
        #23;
        n_checks++;
        if ({out_valid, busy, done, out_last} !== 4'b0 || serial_out !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b last=%b serial_out=%h expected all 0",
                     out_valid, busy, done, out_last, serial_out);
        end
`ifdef PTS_LOAD_ERR_EN
        n_checks++;
        if (load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_load_err: load_err=%b expected 0", load_err);
        end
`endif
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_idle;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_%0d: out_valid=%b busy=%b done=%b expected 0 0 0",
                         c, out_valid, busy, done);
            end
        end
    endtask

    task automatic test_basic;
        load_frame(0);
        drain(-1, 0, -1, -1, -1, NW);
`ifdef PTS_LOAD_ERR_EN
        n_checks++;
        if (load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_err_clean: load_err=%b expected 0", load_err);
        end
`endif
    endtask

    task automatic test_stall;
        load_frame(0);
        drain(5, 3, -1, -1, -1, NW + 3);
    endtask

    task automatic test_load_ignored;
        load_frame(0);
        drain(-1, 0, 10, -1, -1, NW);
`ifdef PTS_LOAD_ERR_EN
        n_checks++;
        if (load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL load_err_sticky: load_err=%b expected 1", load_err);
        end
`endif
    endtask

    task automatic test_reset_mid;
        load_frame(0);
        drain(-1, 0, -1, 20, -1, 0);
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, out_last, done} !== 4'b0 || serial_out !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b busy=%b last=%b done=%b serial_out=%h expected all 0",
                     out_valid, busy, out_last, done, serial_out);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: done=%b out_valid=%b expected 0 0", done, out_valid);
        end
        load_frame(16'h0200);
        drain(-1, 0, -1, -1, -1, NW);
    endtask

    task automatic test_back_to_back;
        load_frame(0);
        drain(-1, 0, NW - 1, -1, 16'h0100, NW);
        drain(-1, 0, -1, -1, -1, NW);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_idle();
        test_basic();
        test_stall();
        test_load_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pts_wrapper
